uart_rx_ctrl: RTL and testbench

//  Parametrised UART receive controller: the next generation of the RX state machine.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_sync.sv | 32 +++
 rtl/uart_rx_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity modes and the
// parity check helper. Intended for both the RX and the future TX controller.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    localparam int unsigned PARITY_NONE = 32'd0;
    localparam int unsigned PARITY_EVEN = 32'd1;
    localparam int unsigned PARITY_ODD  = 32'd2;

    // data_xor is the XOR of all payload bits; odd_mode selects odd parity.
    function automatic logic parity_mismatch(input logic data_xor,
                                             input logic par_bit,
                                             input logic odd_mode);
        return ((data_xor ^ par_bit) != odd_mode);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the raw rxd pin plus a falling-edge detector on
// the synchronised line. All flops reset to the idle (high) line level so a
// reset never fabricates a start edge.
module uart_rx_sync (
    input  logic bclkx8,
    input  logic rst,
    input  logic rxd,
    output logic rxd_s,
    output logic fall_det
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchronise rxd and keep one delayed copy for edge detection
    always_ff @(posedge bclkx8 or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= rxd;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rxd_s    = sync_q;
    assign fall_det = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start detection, mid-bit sampling, payload shift,
// optional parity, one or two checked stop bits and a valid/ready output
// register with overrun reporting. Runs entirely on the oversampled clock.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned OVERSAMPLE  = 8,
    parameter int unsigned PARITY_MODE = 0,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic                 bclkx8,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int unsigned CT1_W = $clog2(OVERSAMPLE);
    localparam int unsigned CT2_W = $clog2(DATA_BITS + 1);

    localparam logic [CT1_W-1:0] CT1_ZERO = {CT1_W{1'b0}};
    localparam logic [CT1_W-1:0] CT1_ONE  = CT1_W'(1);
    localparam logic [CT1_W-1:0] CT1_MID  = CT1_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CT1_W-1:0] CT1_LAST = CT1_W'(OVERSAMPLE - 1);

    localparam logic [CT2_W-1:0] CT2_ZERO      = {CT2_W{1'b0}};
    localparam logic [CT2_W-1:0] CT2_ONE       = CT2_W'(1);
    localparam logic [CT2_W-1:0] CT2_DATA_LAST = CT2_W'(DATA_BITS - 1);
    localparam logic [CT2_W-1:0] CT2_STOP_LAST = CT2_W'(STOP_BITS - 1);

    localparam logic HAS_PARITY = (PARITY_MODE != PARITY_NONE) ? 1'b1 : 1'b0;
    localparam logic ODD_MODE   = (PARITY_MODE == PARITY_ODD)  ? 1'b1 : 1'b0;

    logic rxd_s;
    logic fall_det;

    rx_state_t            state_q,       state_d;
    logic [CT1_W-1:0]     ct1_q,         ct1_d;
    logic [CT2_W-1:0]     ct2_q,         ct2_d;
    logic [DATA_BITS-1:0] shift_q,       shift_d;
    logic                 par_err_q,     par_err_d;
    logic [DATA_BITS-1:0] rx_data_q,     rx_data_d;
    logic                 rx_valid_q,    rx_valid_d;
    logic                 frame_err_q,   frame_err_d;
    logic                 parity_err_q,  parity_err_d;
    logic                 overrun_err_q, overrun_err_d;
    logic                 busy_q,        busy_d;
    logic                 complete_s;
    logic                 bit_tick_s;

    uart_rx_sync u_sync (
        .bclkx8   (bclkx8),
        .rst      (rst),
        .rxd      (rxd),
        .rxd_s    (rxd_s),
        .fall_det (fall_det)
    );

    assign bit_tick_s = (ct1_q == CT1_LAST);

    // Next-state logic: frame FSM, counters, shift register and handshake
    always_comb begin
        state_d       = state_q;
        ct1_d         = ct1_q;
        ct2_d         = ct2_q;
        shift_d       = shift_q;
        par_err_d     = par_err_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        frame_err_d   = 1'b0;
        parity_err_d  = 1'b0;
        overrun_err_d = 1'b0;
        complete_s    = 1'b0;

        // Consumer handshake; a completion below may re-assert valid
        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end

        case (state_q)
            RX_IDLE: begin
                ct1_d     = CT1_ZERO;
                ct2_d     = CT2_ZERO;
                par_err_d = 1'b0;
                if (fall_det) begin
                    state_d = RX_START;
                end else begin
                    state_d = RX_IDLE;
                end
            end

            RX_START: begin
                // Half-bit check both rejects glitches and aligns to mid-bit
                if (ct1_q == CT1_MID) begin
                    ct1_d = CT1_ZERO;
                    ct2_d = CT2_ZERO;
                    if (rxd_s) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d = RX_DATA;
                    end
                end else begin
                    ct1_d = ct1_q + CT1_ONE;
                end
            end

            RX_DATA: begin
                if (bit_tick_s) begin
                    shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
                    ct1_d   = CT1_ZERO;
                    if (ct2_q == CT2_DATA_LAST) begin
                        ct2_d   = CT2_ZERO;
                        state_d = HAS_PARITY ? RX_PARITY : RX_STOP;
                    end else begin
                        ct2_d = ct2_q + CT2_ONE;
                    end
                end else begin
                    ct1_d = ct1_q + CT1_ONE;
                end
            end

            RX_PARITY: begin
                if (bit_tick_s) begin
                    par_err_d = parity_mismatch(^shift_q, rxd_s, ODD_MODE);
                    ct1_d     = CT1_ZERO;
                    state_d   = RX_STOP;
                end else begin
                    ct1_d = ct1_q + CT1_ONE;
                end
            end

            RX_STOP: begin
                if (bit_tick_s) begin
                    ct1_d = CT1_ZERO;
                    if (!rxd_s) begin
                        frame_err_d = 1'b1;
                        state_d     = RX_IDLE;
                    end else if (ct2_q == CT2_STOP_LAST) begin
                        state_d = RX_IDLE;
                        if (par_err_q) begin
                            parity_err_d = 1'b1;
                        end else begin
                            complete_s = 1'b1;
                        end
                    end else begin
                        ct2_d = ct2_q + CT2_ONE;
                    end
                end else begin
                    ct1_d = ct1_q + CT1_ONE;
                end
            end

            default: begin
                state_d = RX_IDLE;
            end
        endcase

        // Load a completed word, or report it lost if the old one is still held
        if (complete_s) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_err_d = 1'b1;
            end
        end else begin
            rx_data_d = rx_data_q;
        end

        busy_d = (state_d != RX_IDLE);
    end

    // State and output registers
    always_ff @(posedge bclkx8 or posedge rst) begin
        if (rst) begin
            state_q       <= RX_IDLE;
            ct1_q         <= CT1_ZERO;
            ct2_q         <= CT2_ZERO;
            shift_q       <= {DATA_BITS{1'b0}};
            par_err_q     <= 1'b0;
            rx_data_q     <= {DATA_BITS{1'b0}};
            rx_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            parity_err_q  <= 1'b0;
            overrun_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ct1_q         <= ct1_d;
            ct2_q         <= ct2_d;
            shift_q       <= shift_d;
            par_err_q     <= par_err_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_err_q   <= frame_err_d;
            parity_err_q  <= parity_err_d;
            overrun_err_q <= overrun_err_d;
            busy_q        <= busy_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_err   = frame_err_q;
    assign parity_err  = parity_err_q;
    assign overrun_err = overrun_err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: dut_a is 8N1, dut_b is 8E2 (both OS=8).
// Stimulus pushes expected words/errors into queues; a negedge monitor pops
// and compares whenever a DUT hands over a word or pulses an error.
module tb_uart_rx_ctrl;

    localparam int OS      = 8;
    localparam int E_FRAME = 1;
    localparam int E_PAR   = 2;
    localparam int E_OVR   = 3;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       rxd_a = 1'b1;
    logic       rxd_b = 1'b1;
    logic       rdy_a = 1'b1;
    logic       rdy_b = 1'b1;
    logic [7:0] data_a, data_b;
    logic       val_a, val_b, fe_a, fe_b, pe_a, pe_b, oe_a, oe_b, busy_a, busy_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rise_a = 0;
    logic va_prev = 1'b0;

    logic [7:0] dq_a[$];
    logic [7:0] dq_b[$];
    int         eq_a[$];
    int         eq_b[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_ctrl #(.DATA_BITS(8), .OVERSAMPLE(8), .PARITY_MODE(0), .STOP_BITS(1)) dut_a (
        .bclkx8(clk), .rst(rst), .rxd(rxd_a), .rx_data(data_a), .rx_valid(val_a),
        .rx_ready(rdy_a), .frame_err(fe_a), .parity_err(pe_a), .overrun_err(oe_a), .busy(busy_a));

    uart_rx_ctrl #(.DATA_BITS(8), .OVERSAMPLE(8), .PARITY_MODE(1), .STOP_BITS(2)) dut_b (
        .bclkx8(clk), .rst(rst), .rxd(rxd_b), .rx_data(data_b), .rx_valid(val_b),
        .rx_ready(rdy_b), .frame_err(fe_b), .parity_err(pe_b), .overrun_err(oe_b), .busy(busy_b));

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, got, exp);
        end
    endtask

    task automatic mon(input int idx, input logic v, input logic r, input logic [7:0] d,
                       input logic fe, input logic pe, input logic oe);
        logic [7:0] exp_d;
        int exp_e;
        int got_e;
        int nq;
        if (v && r) begin
            checks++;
            nq = (idx == 0) ? dq_a.size() : dq_b.size();
            if (nq == 0) begin
                errors++;
                $display("FAIL dut%0d_word: got 0x%02h, required no word", idx, d);
            end else begin
                if (idx == 0) exp_d = dq_a.pop_front();
                else          exp_d = dq_b.pop_front();
                if (d !== exp_d) begin
                    errors++;
                    $display("FAIL dut%0d_word: got 0x%02h, required 0x%02h", idx, d, exp_d);
                end
            end
        end
        if (fe || pe || oe) begin
            checks++;
            if (int'(fe) + int'(pe) + int'(oe) > 1) got_e = 9;
            else if (fe)                            got_e = E_FRAME;
            else if (pe)                            got_e = E_PAR;
            else                                    got_e = E_OVR;
            nq = (idx == 0) ? eq_a.size() : eq_b.size();
            if (nq == 0) begin
                errors++;
                $display("FAIL dut%0d_err: got code %0d, required no error", idx, got_e);
            end else begin
                if (idx == 0) exp_e = eq_a.pop_front();
                else          exp_e = eq_b.pop_front();
                if (got_e != exp_e) begin
                    errors++;
                    $display("FAIL dut%0d_err: got code %0d, required code %0d", idx, got_e, exp_e);
                end
            end
        end
    endtask

    // Monitor: compare every handed-over word and every error pulse
    always @(negedge clk) begin
        if (!rst) begin
            mon(0, val_a, rdy_a, data_a, fe_a, pe_a, oe_a);
            mon(1, val_b, rdy_b, data_b, fe_b, pe_b, oe_b);
        end
        if (val_a && !va_prev) rise_a <= cyc;
        va_prev <= val_a;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rxd(input int idx, input logic b);
        if (idx == 0) rxd_a = b;
        else          rxd_b = b;
    endtask

    task automatic exp_word(input int idx, input logic [7:0] d);
        if (idx == 0) dq_a.push_back(d);
        else          dq_b.push_back(d);
    endtask

    task automatic exp_err(input int idx, input int e);
        if (idx == 0) eq_a.push_back(e);
        else          eq_b.push_back(e);
    endtask

    // Line image of a frame, LSB first from bit 0; bad_stop = k forces stop bit k low
    function automatic int build_frame(input logic [7:0] d, input logic par_en,
                                       input logic par_flip, input int nstop,
                                       input int bad_stop, output logic [15:0] bits);
        int n;
        bits    = 16'hFFFF;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        n = 9;
        if (par_en) begin
            bits[n] = (^d) ^ par_flip;
            n++;
        end
        for (int s = 0; s < nstop; s++) begin
            bits[n] = (bad_stop == s + 1) ? 1'b0 : 1'b1;
            n++;
        end
        return n;
    endfunction

    task automatic send_raw(input int idx, input logic [15:0] bits, input int n);
        for (int k = 0; k < n; k++) begin
            set_rxd(idx, bits[k]);
            repeat (OS) tick();
        end
    endtask

    task automatic idle(input int idx, input int n);
        set_rxd(idx, 1'b1);
        repeat (n) tick();
    endtask

    task automatic send(input int idx, input logic [7:0] d, input logic flip, input int bad);
        logic [15:0] bits;
        int n;
        if (idx == 0) n = build_frame(d, 1'b0, 1'b0, 1, bad, bits);
        else          n = build_frame(d, 1'b1, flip, 2, bad, bits);
        send_raw(idx, bits, n);
    endtask

    initial begin
        logic [15:0] bits;
        logic [7:0]  d;
        logic        flip;
        int          n;
        int          start;
        int          bad;
        int          r;

        repeat (3) @(posedge clk);
        #1;
        cmp("reset_a", {19'd0, data_a, val_a, fe_a, pe_a, oe_a, busy_a}, 32'd0);
        cmp("reset_b", {19'd0, data_b, val_b, fe_b, pe_b, oe_b, busy_b}, 32'd0);
        rst = 1'b0;
        repeat (4) tick();

        // 8N1 0xA5 with ready held high, plus latency from first low sample
        start = cyc;
        exp_word(0, 8'hA5);
        send(0, 8'hA5, 1'b0, 0);
        idle(0, 16);
        cmp("latency_a5", rise_a - start - 1, 32'd78);
        cmp("valid_one_cycle", {31'd0, val_a}, 32'd0);

        // Even parity: 0x3C has four ones, so a parity bit of 1 is wrong
        exp_err(1, E_PAR);
        send(1, 8'h3C, 1'b1, 0);
        idle(1, 16);
        cmp("par_err_no_valid", {31'd0, val_b}, 32'd0);
        exp_word(1, 8'h3C);
        send(1, 8'h3C, 1'b0, 0);
        idle(1, 16);

        // Two-tick glitch is rejected at the half-bit check
        rxd_a = 1'b0;
        repeat (2) tick();
        rxd_a = 1'b1;
        repeat (3) tick();
        cmp("glitch_busy_hi", {31'd0, busy_a}, 32'd1);
        repeat (6) tick();
        cmp("glitch_busy_lo", {31'd0, busy_a}, 32'd0);
        cmp("glitch_no_valid", {31'd0, val_a}, 32'd0);

        // Overrun: 0x11 held, 0x22 lost
        rdy_a = 1'b0;
        exp_word(0, 8'h11);
        send(0, 8'h11, 1'b0, 0);
        idle(0, 4);
        exp_err(0, E_OVR);
        send(0, 8'h22, 1'b0, 0);
        idle(0, 4);
        cmp("hold_data", {24'd0, data_a}, 32'h11);
        cmp("hold_valid", {31'd0, val_a}, 32'd1);
        rdy_a = 1'b1;
        tick();
        rdy_a = 1'b0;
        cmp("accepted_clear", {31'd0, val_a}, 32'd0);

        // Acceptance in the very completion cycle loads the new word, no overrun
        exp_word(0, 8'h33);
        send(0, 8'h33, 1'b0, 0);
        idle(0, 4);
        exp_word(0, 8'h44);
        fork
            send(0, 8'h44, 1'b0, 0);
            begin
                repeat (78) tick();
                rdy_a = 1'b1;
                tick();
                rdy_a = 1'b0;
            end
        join
        idle(0, 4);
        cmp("same_cycle_data", {24'd0, data_a}, 32'h44);
        cmp("same_cycle_valid", {31'd0, val_a}, 32'd1);
        rdy_a = 1'b1;
        idle(0, 4);

        // Second stop bit low, then line stays low: no restart
        exp_err(1, E_FRAME);
        send(1, 8'h55, 1'b0, 2);
        repeat (40) tick();
        cmp("held_low_busy", {31'd0, busy_b}, 32'd0);
        idle(1, 8);
        exp_word(1, 8'h55);
        send(1, 8'h55, 1'b0, 0);
        idle(1, 8);

        // Reset during data bit 4 abandons the frame
        n = build_frame(8'h5A, 1'b0, 1'b0, 1, 0, bits);
        send_raw(0, bits, 5);
        repeat (4) tick();
        rst = 1'b1;
        #1;
        cmp("mid_reset_a", {19'd0, data_a, val_a, fe_a, pe_a, oe_a, busy_a}, 32'd0);
        rxd_a = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (4) tick();
        exp_word(0, 8'hF0);
        send(0, 8'hF0, 1'b0, 0);
        idle(0, 8);

        // Randomised frames with injected errors and gaps down to zero
        for (int i = 0; i < 40; i++) begin
            int idx;
            idx  = i % 2;
            d    = 8'($urandom());
            flip = 1'b0;
            bad  = 0;
            if (idx == 0) begin
                bad = ($urandom_range(0, 3) == 0) ? 1 : 0;
            end else begin
                flip = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
                r    = int'($urandom_range(0, 5));
                bad  = (r < 2) ? r + 1 : 0;
            end
            if (bad != 0)  exp_err(idx, E_FRAME);
            else if (flip) exp_err(idx, E_PAR);
            else           exp_word(idx, d);
            send(idx, d, flip, bad);
            if (bad != 0) idle(idx, int'($urandom_range(8, 16)));
            else          idle(idx, int'($urandom_range(0, 12)));
        end

        // Drain, bounded
        for (int w = 0; w < 300; w++) begin
            if (dq_a.size() + dq_b.size() + eq_a.size() + eq_b.size() == 0) break;
            tick();
        end
        cmp("drain_words_a", dq_a.size(), 32'd0);
        cmp("drain_words_b", dq_b.size(), 32'd0);
        cmp("drain_errs_a", eq_a.size(), 32'd0);
        cmp("drain_errs_b", eq_b.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
